ncap_irq_ctrl: RTL and testbench

Interrupt delivery stage directly downstream of the NCAP power-mode controller. Captures its single-cycle `interrupt`/`interrupt_type` pulses into a one-deep pending slot (newest event wins) and issues them as MSI requests over a req/ack handshake. Enforces a programmable minimum gap between deliveries and exposes a read-to-clear cause register and saturating statistics to the driver.

---
 rtl/ncap_pkg.sv | 15 +
 rtl/ncap_sat_counter.sv | 14 +
 rtl/ncap_irq_ctrl.sv | 110 +++++++++++
 tb/tb_ncap_irq_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ncap_pkg.sv
// Shared NCAP definitions: interrupt type codes, delivery FSM encoding and
// default MSI vectors.
package ncap_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic INTR_HIGH = 1'b1;
  localparam logic INTR_LOW  = 1'b0;

  localparam int DEF_VEC_HIGH = 0;
  localparam int DEF_VEC_LOW  = 1;
endpackage

// File: rtl/ncap_sat_counter.sv
// Width-parameterized saturating event counter; sticks at all-ones.
module ncap_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n)                cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/ncap_irq_ctrl.sv
// Captures NCAP interrupt pulses into a one-deep slot and delivers them as
// MSI requests with a programmable post-delivery gap.
module ncap_irq_ctrl
  import ncap_pkg::*;
#(
  parameter int VEC_W    = 5,
  parameter int VEC_HIGH = DEF_VEC_HIGH,
  parameter int VEC_LOW  = DEF_VEC_LOW,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ncap_interrupt,
  input  logic             ncap_interrupt_type,
  input  logic             irq_enable,
  input  logic [31:0]      min_gap,
  input  logic             cause_rd,
  output logic             msi_req,
  output logic [VEC_W-1:0] msi_vector,
  input  logic             msi_ack,
  input  logic             msi_fail,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] sent_high,
  output logic [CNT_W-1:0] sent_low,
  output logic [CNT_W-1:0] coalesced
);
  localparam logic [VEC_W-1:0] V_HI = VEC_W'(VEC_HIGH);
  localparam logic [VEC_W-1:0] V_LO = VEC_W'(VEC_LOW);

  state_t      state, state_nxt;
  logic        pend_v, pend_t, fl_t;
  logic [31:0] gap_cnt;
  logic        launch, ack_take, fail_take;
  logic [1:0]  cause_set;
  logic        inc_high, inc_low, inc_coal;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    ack_take  = 1'b0;
    fail_take = 1'b0;
    case (state)
      ST_IDLE: if (pend_v && irq_enable) begin
        launch    = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_REQ: if (msi_ack) begin
        ack_take  = 1'b1;
        state_nxt = ST_GAP;
      end else if (msi_fail) begin
        fail_take = 1'b1;
        state_nxt = ST_GAP;
      end
      ST_GAP: if (gap_cnt == 32'd0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cause_set = ack_take ? ((fl_t == INTR_HIGH) ? 2'b10 : 2'b01) : 2'b00;
  assign inc_high  = ack_take && (fl_t == INTR_HIGH);
  assign inc_low   = ack_take && (fl_t == INTR_LOW);
  // One count per cycle in which any event is lost: an overwritten slot, or a
  // failed in-flight request that cannot return to the slot.
  assign inc_coal  = (ncap_interrupt && pend_v && !launch) ||
                     (fail_take && (pend_v || ncap_interrupt));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_v     <= 1'b0;
      pend_t     <= 1'b0;
      fl_t       <= 1'b0;
      gap_cnt    <= '0;
      msi_req    <= 1'b0;
      msi_vector <= '0;
      cause      <= '0;
    end else begin
      cause <= (cause & ~{2{cause_rd}}) | cause_set;
      if (launch) begin
        fl_t       <= pend_t;
        pend_v     <= 1'b0;
        msi_req    <= 1'b1;
        msi_vector <= (pend_t == INTR_HIGH) ? V_HI : V_LO;
      end
      if (ack_take || fail_take) begin
        msi_req <= 1'b0;
        gap_cnt <= min_gap;
      end else if (state == ST_GAP && gap_cnt != 32'd0) begin
        gap_cnt <= gap_cnt - 32'd1;
      end
      if (fail_take && !pend_v) begin
        pend_v <= 1'b1;
        pend_t <= fl_t;
      end
      // A fresh pulse always lands in the slot, overriding clear or restore.
      if (ncap_interrupt) begin
        pend_v <= 1'b1;
        pend_t <= ncap_interrupt_type;
      end
    end
  end

  ncap_sat_counter #(.W(CNT_W)) u_cnt_high (.clk(clk), .rst_n(rst_n), .inc(inc_high), .cnt(sent_high));
  ncap_sat_counter #(.W(CNT_W)) u_cnt_low  (.clk(clk), .rst_n(rst_n), .inc(inc_low),  .cnt(sent_low));
  ncap_sat_counter #(.W(CNT_W)) u_cnt_coal (.clk(clk), .rst_n(rst_n), .inc(inc_coal), .cnt(coalesced));
endmodule

// File: tb/tb_ncap_irq_ctrl.sv
// Self-checking bench for ncap_irq_ctrl: directed table, hand sequences and
// randomized traffic against a timestamp-based reference model.
module tb_ncap_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, pulse, ptype, en, rd, ack, fail;
  logic [31:0] gap;
  logic        req, req_s;
  logic [4:0]  vec, vec_s;
  logic [1:0]  cause, cause_s;
  logic [15:0] sh, sl, co;
  logic [1:0]  sh_s, sl_s, co_s;

  always #5 clk = ~clk;

  ncap_irq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ncap_interrupt(pulse), .ncap_interrupt_type(ptype),
    .irq_enable(en), .min_gap(gap), .cause_rd(rd), .msi_req(req), .msi_vector(vec),
    .msi_ack(ack), .msi_fail(fail), .cause(cause), .sent_high(sh), .sent_low(sl),
    .coalesced(co));

  // Narrow-counter copy so saturation is reached quickly.
  ncap_irq_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .ncap_interrupt(pulse), .ncap_interrupt_type(ptype),
    .irq_enable(en), .min_gap(gap), .cause_rd(rd), .msi_req(req_s), .msi_vector(vec_s),
    .msi_ack(ack), .msi_fail(fail), .cause(cause_s), .sent_high(sh_s), .sent_low(sl_s),
    .coalesced(co_s));

  int tests = 0, fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: delivery allowed once the cycle index reaches ready_at.
  longint cyc_n = 0, ready_at = 0;
  bit     m_infl, m_pv, m_pt, m_flt;
  int     m_vec, m_cause, m_sh, m_sl, m_co;

  function automatic longint sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step();
    bit drop;
    int set;
    if (!rst_n) begin
      m_infl = 0; m_pv = 0; m_pt = 0; m_flt = 0;
      m_vec = 0; m_cause = 0; m_sh = 0; m_sl = 0; m_co = 0;
      ready_at = cyc_n + 1;
    end else begin
      drop = 0; set = 0;
      if (!m_infl && cyc_n >= ready_at && m_pv && en) begin
        m_infl = 1; m_flt = m_pt; m_pv = 0;
        m_vec = m_pt ? 0 : 1;
      end else if (m_infl && (ack || fail)) begin
        m_infl = 0;
        ready_at = cyc_n + longint'(gap) + 2;
        if (ack) begin
          set = m_flt ? 2 : 1;
          if (m_flt) m_sh++; else m_sl++;
        end else if (m_pv) drop = 1;
        else begin m_pv = 1; m_pt = m_flt; end
      end
      if (rd) m_cause = 0;
      m_cause |= set;
      if (pulse) begin
        if (m_pv) drop = 1;
        m_pv = 1; m_pt = ptype;
      end
      if (drop) m_co++;
    end
    cyc_n++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("req", req, m_infl);
    chk("vec", vec, m_vec);
    chk("cause", cause, m_cause);
    chk("sent_high", sh, sat(m_sh, 65535));
    chk("sent_low", sl, sat(m_sl, 65535));
    chk("coalesced", co, sat(m_co, 65535));
    chk("req_s", req_s, m_infl);
    chk("sent_high_s", sh_s, sat(m_sh, 3));
    chk("sent_low_s", sl_s, sat(m_sl, 3));
    chk("coalesced_s", co_s, sat(m_co, 3));
  endtask

  task automatic idle_in();
    pulse = 0; ptype = 0; rd = 0; ack = 0; fail = 0;
  endtask

  typedef struct packed {
    logic       p, t, a, f, r;
    logic       exp_req;
    logic [4:0] exp_vec;
    logic [1:0] exp_cause;
  } row_t;

  function automatic row_t mk(input logic p, t, a, f, r, q, input logic [4:0] v,
                              input logic [1:0] c);
    row_t x;
    x.p = p; x.t = t; x.a = a; x.f = f; x.r = r;
    x.exp_req = q; x.exp_vec = v; x.exp_cause = c;
    return x;
  endfunction

  row_t tbl[19];

  initial begin
    // HIGH delivery, gap, LOW delivery with one failed attempt and retry,
    // then ack coinciding with a cause read.
    tbl[0]  = mk(1,1,0,0,0, 0,0,0);
    tbl[1]  = mk(0,0,0,0,0, 1,0,0);
    tbl[2]  = mk(0,0,0,0,0, 1,0,0);
    tbl[3]  = mk(0,0,0,0,0, 1,0,0);
    tbl[4]  = mk(0,0,1,0,0, 0,0,2);
    tbl[5]  = mk(1,0,0,0,0, 0,0,2);
    for (int i = 6; i <= 9; i++) tbl[i] = mk(0,0,0,0,0, 0,0,2);
    tbl[10] = mk(0,0,0,0,0, 1,1,2);
    tbl[11] = mk(0,0,0,1,0, 0,1,2);
    for (int i = 12; i <= 16; i++) tbl[i] = mk(0,0,0,0,0, 0,1,2);
    tbl[17] = mk(0,0,0,0,0, 1,1,2);
    tbl[18] = mk(0,0,1,0,1, 0,1,1);

    idle_in(); en = 1; gap = 32'd4; rst_n = 0;
    cyc(); cyc();
    chk("rst_req", req, 0);
    chk("rst_vec", vec, 0);
    chk("rst_cause", cause, 0);
    chk("rst_cnt", {sh, sl, co}, 0);
    rst_n = 1;

    for (int i = 0; i < 19; i++) begin
      pulse = tbl[i].p; ptype = tbl[i].t; ack = tbl[i].a; fail = tbl[i].f; rd = tbl[i].r;
      cyc();
      chk($sformatf("tbl%0d_req", i), req, tbl[i].exp_req);
      chk($sformatf("tbl%0d_vec", i), vec, tbl[i].exp_vec);
      chk($sformatf("tbl%0d_cause", i), cause, tbl[i].exp_cause);
    end
    idle_in();
    chk("tbl_sent_high", sh, 1);
    chk("tbl_sent_low", sl, 1);
    chk("tbl_coalesced", co, 0);

    // Two pulses while gated: newest (HIGH) wins and one event is counted lost.
    repeat (6) cyc();
    en = 0;
    pulse = 1; ptype = 0; cyc();
    pulse = 1; ptype = 1; cyc();
    idle_in(); cyc(); cyc();
    chk("gated_req", req, 0);
    chk("gated_coal", co, 1);
    en = 1; cyc();
    chk("enable_req", req, 1);
    chk("enable_vec", vec, 0);
    ack = 1; cyc(); idle_in();
    chk("enable_cause", cause, 3);
    chk("enable_sent_high", sh, 2);

    // Reset while a LOW request is outstanding.
    pulse = 1; ptype = 0; cyc(); idle_in();
    repeat (6) cyc();
    chk("pre_rst_req", req, 1);
    chk("pre_rst_vec", vec, 1);
    rst_n = 0; cyc(); rst_n = 1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_cause", cause, 0);
    chk("mid_rst_cnt", {sh, sl, co}, 0);

    // Randomized traffic with min_gap changing under the model.
    for (int i = 0; i < 3000; i++) begin
      pulse = ($urandom_range(0, 5) == 0);
      ptype = $urandom_range(0, 1);
      en    = ($urandom_range(0, 9) < 8);
      ack   = ($urandom_range(0, 9) < 3);
      fail  = ($urandom_range(0, 9) == 0);
      rd    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) gap = $urandom_range(0, 5);
      cyc();
    end
    idle_in();
    if (m_sl >= 3) chk("sat_sent_low", sl_s, 3);
    if (m_sh >= 3) chk("sat_sent_high", sh_s, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
